// File: rtl/wb_collector_pkg.sv
// Shared types for the writeback collector: source enumeration, beat payload
// and the exception record carried alongside each result.
package wb_collector_pkg;

  localparam int XLEN          = 64;
  localparam int TRANS_ID_BITS = 3;
  localparam int NR_WB_SRC     = 5;

  typedef logic [XLEN-1:0] xlen_t;

  typedef struct packed {
    xlen_t cause;
    xlen_t tval;
    logic  valid;
  } exception_t;

  typedef enum logic [2:0] {
    WB_FLU   = 3'd0,
    WB_LOAD  = 3'd1,
    WB_STORE = 3'd2,
    WB_FPU   = 3'd3,
    WB_X     = 3'd4
  } wb_src_e;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    xlen_t                    result;
    exception_t               ex;
    logic                     we;
  } wb_entry_t;

  // Wrap a source index in 0..9 back into 0..4.
  function automatic logic [2:0] wb_src_wrap(input logic [3:0] idx);
    logic [3:0] r;
    r = (idx >= 4'd5) ? idx - 4'd5 : idx;
    return r[2:0];
  endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source beat buffer. DEPTH must be a power of two so the pointers wrap
// naturally. The caller never pushes into a full FIFO unless it also pops,
// and never pops an empty one.
module wb_src_fifo
  import wb_collector_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      flush_i,
  input  logic      push_i,
  input  wb_entry_t data_i,
  input  logic      pop_i,
  output wb_entry_t data_o,
  output logic      empty_o,
  output logic      full_o,
  output logic      almost_full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];

  // Next pointer/count/storage; flush empties the FIFO and ignores any push.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage; contents are only observed while the count says they are valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign data_o        = mem_q[rd_ptr_q];
  assign empty_o       = (cnt_q == '0);
  assign full_o        = (cnt_q == CNT_W'(DEPTH));
  assign almost_full_o = (cnt_q >= CNT_W'(DEPTH - 1));

endmodule

// File: rtl/wb_collector.sv
// Writeback collector: buffers the five execute-stage producers, arbitrates
// them round-robin onto NrWbPorts scoreboard write ports and flags dropped
// beats. Optional macro WB_COLLECT_BYPASS_EN lets a beat arriving at an empty
// FIFO go straight to a write port in the same cycle.
module wb_collector
  import wb_collector_pkg::*;
#(
  parameter int NrWbPorts = 2,
  parameter int FifoDepth = 2
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      flush_i,
  input  logic [NR_WB_SRC-1:0]                      src_valid_i,
  input  logic [NR_WB_SRC-1:0][TRANS_ID_BITS-1:0]   src_trans_id_i,
  input  xlen_t [NR_WB_SRC-1:0]                     src_result_i,
  input  exception_t [NR_WB_SRC-1:0]                src_exception_i,
  input  logic [NR_WB_SRC-1:0]                      src_we_i,
  output logic [NR_WB_SRC-1:0]                      src_almost_full_o,
  output logic [NrWbPorts-1:0]                      wb_valid_o,
  output logic [NrWbPorts-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_o,
  output xlen_t [NrWbPorts-1:0]                     wb_result_o,
  output exception_t [NrWbPorts-1:0]                wb_exception_o,
  output logic [NrWbPorts-1:0]                      wb_we_o,
  output logic                                      overflow_o
);

  wb_entry_t            in_beat   [NR_WB_SRC];
  wb_entry_t            fifo_head [NR_WB_SRC];
  wb_entry_t            head      [NR_WB_SRC];
  logic [NR_WB_SRC-1:0] fifo_empty;
  logic [NR_WB_SRC-1:0] fifo_full;
  logic [NR_WB_SRC-1:0] fifo_af;
  logic [NR_WB_SRC-1:0] eligible;
  logic [NR_WB_SRC-1:0] src_granted;
  logic [NR_WB_SRC-1:0] push;
  logic [NR_WB_SRC-1:0] pop;
  logic [NR_WB_SRC-1:0] drop;
  logic [NrWbPorts-1:0] grant_vld;
  logic [2:0]           grant_src [NrWbPorts];
  logic [2:0]           rr_ptr_q, rr_ptr_d;
  logic                 overflow_q, overflow_d;

  for (genvar s = 0; s < NR_WB_SRC; s++) begin : g_fifo
    wb_src_fifo #(
      .DEPTH (FifoDepth)
    ) i_fifo (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .flush_i       (flush_i),
      .push_i        (push[s]),
      .data_i        (in_beat[s]),
      .pop_i         (pop[s]),
      .data_o        (fifo_head[s]),
      .empty_o       (fifo_empty[s]),
      .full_o        (fifo_full[s]),
      .almost_full_o (fifo_af[s])
    );
  end

  // Per-source candidate beat and eligibility; nothing is eligible in reset or flush.
  always_comb begin
    for (int s = 0; s < NR_WB_SRC; s++) begin
      in_beat[s] = '{trans_id: src_trans_id_i[s],
                     result:   src_result_i[s],
                     ex:       src_exception_i[s],
                     we:       src_we_i[s]};
`ifdef WB_COLLECT_BYPASS_EN
      head[s]     = fifo_empty[s] ? in_beat[s] : fifo_head[s];
      eligible[s] = ~fifo_empty[s] | src_valid_i[s];
`else
      head[s]     = fifo_head[s];
      eligible[s] = ~fifo_empty[s];
`endif
    end
    if (rst_i || flush_i) begin
      eligible = '0;
    end
  end

  // Round-robin scan from rr_ptr, packing grants onto the lowest free port.
  always_comb begin
    int         n;
    logic [2:0] idx;
    n           = 0;
    idx         = '0;
    grant_vld   = '0;
    src_granted = '0;
    rr_ptr_d    = rr_ptr_q;
    for (int p = 0; p < NrWbPorts; p++) begin
      grant_src[p] = '0;
    end
    for (int k = 0; k < NR_WB_SRC; k++) begin
      idx = wb_src_wrap({1'b0, rr_ptr_q} + 4'(k));
      if (eligible[idx] && (n < NrWbPorts)) begin
        for (int p = 0; p < NrWbPorts; p++) begin
          if (n == p) begin
            grant_vld[p] = 1'b1;
            grant_src[p] = idx;
          end
        end
        src_granted[idx] = 1'b1;
        rr_ptr_d         = wb_src_wrap({1'b0, idx} + 4'd1);
        n                = n + 1;
      end
    end
  end

  // FIFO push/pop and drop detection. A granted beat on an empty FIFO was
  // bypassed, so it is not pushed.
  always_comb begin
    logic live;
    logic bypassed;
    live     = 1'b0;
    bypassed = 1'b0;
    push     = '0;
    pop      = '0;
    drop     = '0;
    for (int s = 0; s < NR_WB_SRC; s++) begin
      live     = src_valid_i[s] & ~flush_i & ~rst_i;
      bypassed = src_granted[s] & fifo_empty[s];
      pop[s]   = src_granted[s] & ~fifo_empty[s];
      push[s]  = live & ~bypassed & (~fifo_full[s] | pop[s]);
      drop[s]  = live & ~bypassed & fifo_full[s] & ~pop[s];
    end
    overflow_d = overflow_q | (|drop);
  end

  // Arbiter pointer and sticky overflow; flush leaves both alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Drive write ports from the granted heads; idle ports are all-zero.
  always_comb begin
    wb_valid_o     = grant_vld;
    wb_trans_id_o  = '0;
    wb_result_o    = '0;
    wb_exception_o = '0;
    wb_we_o        = '0;
    for (int p = 0; p < NrWbPorts; p++) begin
      if (grant_vld[p]) begin
        wb_trans_id_o[p]  = head[grant_src[p]].trans_id;
        wb_result_o[p]    = head[grant_src[p]].result;
        wb_exception_o[p] = head[grant_src[p]].ex;
        wb_we_o[p]        = head[grant_src[p]].we;
      end
    end
  end

  assign src_almost_full_o = fifo_af;
  assign overflow_o        = overflow_q;

endmodule
